// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register-file write-port arbiter: writeback first, long-latency FIFO drain, pending scoreboard
// Optional feature macro: RF_ARB_BYPASS_EN (direct write of an LU return into an idle port with an empty FIFO)
module rf_write_arbiter #(
    parameter int DATA_WIDTH   = 64,
    parameter int REG_ADDR_W   = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          i_clk,
    input  logic                          i_arst,
    input  logic                          i_wb_we,
    input  logic [REG_ADDR_W-1:0]         i_wb_rd_addr,
    input  logic [DATA_WIDTH-1:0]         i_wb_data,
    input  logic                          i_lu_valid,
    input  logic [REG_ADDR_W-1:0]         i_lu_rd_addr,
    input  logic [DATA_WIDTH-1:0]         i_lu_data,
    output logic                          o_lu_ready,
    input  logic                          i_issue,
    input  logic [REG_ADDR_W-1:0]         i_issue_rd,
    input  logic [REG_ADDR_W-1:0]         i_rs1_addr,
    input  logic [REG_ADDR_W-1:0]         i_rs2_addr,
    input  logic [REG_ADDR_W-1:0]         i_dec_rd_addr,
    output logic                          o_stall,
    output logic                          o_wb_hold,
    output logic                          o_rf_we,
    output logic [REG_ADDR_W-1:0]         o_rf_rd_addr,
    output logic [DATA_WIDTH-1:0]         o_rf_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_pending_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2 ** REG_ADDR_W;
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

    logic [REG_ADDR_W-1:0] fifo_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];

    logic [CNT_W-1:0] wr_ptr, rd_ptr, count;
    logic [NREG-1:0]  sb, sb_next, set_mask, clr_mask;
    logic [ST_W-1:0]  starve, starve_next;
    logic             wb_hold, hold_next;
    logic             empty, full, wb_active, port_free, pop, push, byp;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [DATA_WIDTH-1:0] head_data;

    assign count     = wr_ptr - rd_ptr;
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign head_rd   = fifo_rd[rd_ptr[PTR_W-1:0]];
    assign head_data = fifo_data[rd_ptr[PTR_W-1:0]];

    // A writeback to x0 writes nothing, so it does not claim the port.
    assign wb_active = i_wb_we & ~wb_hold & (|i_wb_rd_addr);
    assign port_free = ~wb_active;
    assign pop       = ~empty & port_free;

`ifdef RF_ARB_BYPASS_EN
    assign byp = i_lu_valid & empty & port_free;
`else
    assign byp = 1'b0;
`endif

    assign o_lu_ready    = ~full;
    assign push          = i_lu_valid & ~full & ~byp;
    assign o_wb_hold     = wb_hold;
    assign o_pending_cnt = count;
    assign o_stall       = sb[i_rs1_addr] | sb[i_rs2_addr] | sb[i_dec_rd_addr];

    always_comb begin
        o_rf_we      = 1'b0;
        o_rf_rd_addr = '0;
        o_rf_data    = '0;
        if (!i_arst) begin
            if (wb_active) begin
                o_rf_we      = 1'b1;
                o_rf_rd_addr = i_wb_rd_addr;
                o_rf_data    = i_wb_data;
            end else if (pop) begin
                o_rf_we      = |head_rd;
                o_rf_rd_addr = head_rd;
                o_rf_data    = head_data;
            end else if (byp) begin
                o_rf_we      = |i_lu_rd_addr;
                o_rf_rd_addr = i_lu_rd_addr;
                o_rf_data    = i_lu_data;
            end
        end
    end

    // Set wins over clear so an issue to a register being retired stays pending.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (i_issue) set_mask[i_issue_rd] = 1'b1;
        if (pop)     clr_mask[head_rd] = 1'b1;
        if (byp)     clr_mask[i_lu_rd_addr] = 1'b1;
        sb_next    = (sb & ~clr_mask) | set_mask;
        sb_next[0] = 1'b0;
    end

    always_comb begin
        starve_next = '0;
        if (!empty && !pop) starve_next = starve + ST_W'(1);
        hold_next = (starve_next == ST_W'(STARVE_LIMIT));
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            sb      <= '0;
            starve  <= '0;
            wb_hold <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + CNT_W'(1);
            if (pop)  rd_ptr <= rd_ptr + CNT_W'(1);
            sb      <= sb_next;
            starve  <= starve_next;
            wb_hold <= hold_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_rd[wr_ptr[PTR_W-1:0]]   <= i_lu_rd_addr;
            fifo_data[wr_ptr[PTR_W-1:0]] <= i_lu_data;
        end
    end
endmodule
